// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a multiplexed, active-low 7-segment display bus.
// Each digit position is debounced by a small tracker: the (an,seg) sample must
// hold steady for STABLE_CYCLES clocks before that position's fields update.
// Once every position has been latched, a one-cycle frame_valid pulse marks a
// complete snapshot, and the capture mask starts over.
module seg_scan_decoder #(
   parameter int N_DIGITS      = 8,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              seg,
   input  logic [N_DIGITS-1:0]     an,
   output logic [4*N_DIGITS-1:0]   digits,
   output logic [N_DIGITS-1:0]     dp,
   output logic [N_DIGITS-1:0]     blank,
   output logic [N_DIGITS-1:0]     err,
   output logic                    frame_valid
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam int LC_W  = $clog2(N_DIGITS + 1);
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, COUNT, HELD} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [N_DIGITS-1:0]     an_st_q, an_st_d;
   logic [7:0]              seg_st_q, seg_st_d;
   logic [N_DIGITS-1:0]     mask_q, mask_d;
   logic [4*N_DIGITS-1:0]   digits_q, digits_d;
   logic [N_DIGITS-1:0]     dp_q, dp_d;
   logic [N_DIGITS-1:0]     blank_q, blank_d;
   logic [N_DIGITS-1:0]     err_q, err_d;
   logic                    frame_valid_q, frame_valid_d;

   logic [LC_W-1:0]         low_cnt;
   logic [IDX_W-1:0]        sel_idx;
   logic                    sample_valid;
   logic                    same_sample;
   logic                    start;
   logic                    latch;
   logic [3:0]              dec_nib;
   logic                    dec_blank;
   logic                    dec_err;

   // Count active digit selects; a sample is usable only with exactly one low.
   always_comb begin
      low_cnt = '0;
      sel_idx = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (!an[i]) begin
            low_cnt = low_cnt + LC_W'(1);
            sel_idx = IDX_W'(i);
         end
      end
   end

   assign sample_valid = (low_cnt == LC_W'(1));
   assign same_sample  = (an == an_st_q) && (seg == seg_st_q);

   // Map the seven segment lines (dp ignored) back to a hex nibble.
   always_comb begin
      dec_nib   = 4'h0;
      dec_blank = 1'b0;
      dec_err   = 1'b0;
      case (seg[7:1])
         7'b0000001: dec_nib = 4'h0;
         7'b1001111: dec_nib = 4'h1;
         7'b0010010: dec_nib = 4'h2;
         7'b0000110: dec_nib = 4'h3;
         7'b1001100: dec_nib = 4'h4;
         7'b0100100: dec_nib = 4'h5;
         7'b0100000: dec_nib = 4'h6;
         7'b0001111: dec_nib = 4'h7;
         7'b0000000: dec_nib = 4'h8;
         7'b0000100: dec_nib = 4'h9;
         7'b0001000: dec_nib = 4'hA;
         7'b1100000: dec_nib = 4'hB;
         7'b0110001: dec_nib = 4'hC;
         7'b1000010: dec_nib = 4'hD;
         7'b0110000: dec_nib = 4'hE;
         7'b0111000: dec_nib = 4'hF;
         7'b1111111: dec_blank = 1'b1;
         default:    dec_err   = 1'b1;
      endcase
   end

   // Stability tracker: restart on any change, give up on an invalid sample,
   // and latch exactly once when the count reaches STABLE_CYCLES.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      an_st_d  = an_st_q;
      seg_st_d = seg_st_q;
      start    = 1'b0;
      latch    = 1'b0;
      case (state_q)
         IDLE: begin
            if (sample_valid) start = 1'b1;
         end
         COUNT: begin
            if (!sample_valid) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (!same_sample) begin
               start = 1'b1;
            end else if (int'(cnt_q) + 1 >= STABLE_CYCLES) begin
               cnt_d   = CNT_W'(STABLE_CYCLES);
               latch   = 1'b1;
               state_d = HELD;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HELD: begin
            if (!sample_valid) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (!same_sample) begin
               start = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      if (start) begin
         an_st_d  = an;
         seg_st_d = seg;
         cnt_d    = CNT_W'(1);
         if (STABLE_CYCLES <= 1) begin
            latch   = 1'b1;
            state_d = HELD;
         end else begin
            state_d = COUNT;
         end
      end
   end

   // Output fields and capture mask: the frame clear happens first, so a latch
   // landing on the clearing edge keeps its mask bit for the next frame.
   always_comb begin
      digits_d      = digits_q;
      dp_d          = dp_q;
      blank_d       = blank_q;
      err_d         = err_q;
      frame_valid_d = &mask_q;
      mask_d        = (&mask_q) ? '0 : mask_q;
      if (latch) begin
         digits_d[4*sel_idx +: 4] = dec_nib;
         dp_d[sel_idx]            = ~seg[0];
         blank_d[sel_idx]         = dec_blank;
         err_d[sel_idx]           = dec_err;
         mask_d[sel_idx]          = 1'b1;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         an_st_q       <= '1;
         seg_st_q      <= '1;
         mask_q        <= '0;
         digits_q      <= '0;
         dp_q          <= '0;
         blank_q       <= '1;
         err_q         <= '0;
         frame_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         an_st_q       <= an_st_d;
         seg_st_q      <= seg_st_d;
         mask_q        <= mask_d;
         digits_q      <= digits_d;
         dp_q          <= dp_d;
         blank_q       <= blank_d;
         err_q         <= err_d;
         frame_valid_q <= frame_valid_d;
      end
   end

   assign digits      = digits_q;
   assign dp          = dp_q;
   assign blank       = blank_q;
   assign err         = err_q;
   assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Testbench for seg_scan_decoder: directed scans of the display bus, with the
// expected snapshot of each full frame queued up front and compared whenever
// the decoder pulses frame_valid.
module tb_seg_scan_decoder;

   logic        clk;
   logic        rst;
   logic [7:0]  seg;
   logic [7:0]  an;
   logic [31:0] digits;
   logic [7:0]  dp;
   logic [7:0]  blank;
   logic [7:0]  err;
   logic        frame_valid;

   typedef struct {
      logic [31:0] digits;
      logic [7:0]  dp;
      logic [7:0]  blank;
      logic [7:0]  err;
   } frame_t;

   frame_t expQ[$];
   int     checks     = 0;
   int     errors     = 0;
   int     frameCount = 0;
   int     fcBase;

   seg_scan_decoder #(.N_DIGITS(8), .STABLE_CYCLES(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg         (seg),
      .an          (an),
      .digits      (digits),
      .dp          (dp),
      .blank       (blank),
      .err         (err),
      .frame_valid (frame_valid)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Encoder-side view of the hex glyphs, active-low a..g.
   function automatic logic [6:0] hexSeg(input logic [3:0] n);
      case (n)
         4'h0: return 7'b0000001;
         4'h1: return 7'b1001111;
         4'h2: return 7'b0010010;
         4'h3: return 7'b0000110;
         4'h4: return 7'b1001100;
         4'h5: return 7'b0100100;
         4'h6: return 7'b0100000;
         4'h7: return 7'b0001111;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0000100;
         4'hA: return 7'b0001000;
         4'hB: return 7'b1100000;
         4'hC: return 7'b0110001;
         4'hD: return 7'b1000010;
         4'hE: return 7'b0110000;
         default: return 7'b0111000;
      endcase
   endfunction

   function automatic logic [7:0] segOf(input logic [3:0] n, input logic dpLit);
      return {hexSeg(n), ~dpLit};
   endfunction

   function automatic logic [7:0] anOf(input int pos);
      logic [7:0] one;
      one = 8'h01;
      return ~(one << pos);
   endfunction

   // One comparison: count it, and on mismatch count and report it.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one bus sample and hold it for the given number of rising edges.
   task automatic applyStimulus(input logic [7:0] anv, input logic [7:0] segv, input int cycles);
      an  = anv;
      seg = segv;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic showDigit(input int pos, input logic [3:0] n, input logic dpLit, input int cycles);
      applyStimulus(anOf(pos), segOf(n, dpLit), cycles);
   endtask

   task automatic pushFrame(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b, input logic [7:0] e);
      frame_t f;
      f.digits = d;
      f.dp     = p;
      f.blank  = b;
      f.err    = e;
      expQ.push_back(f);
   endtask

   // Scoreboard: every frame_valid pulse must match the oldest queued frame.
   always @(negedge clk) begin
      if (!rst && frame_valid) begin
         frame_t f;
         frameCount++;
         if (expQ.size() == 0) begin
            checkOutput("unexpected_frame", 32'd1, 32'd0);
         end else begin
            f = expQ.pop_front();
            checkOutput("frame_digits", digits, f.digits);
            checkOutput("frame_dp", {24'd0, dp}, {24'd0, f.dp});
            checkOutput("frame_blank", {24'd0, blank}, {24'd0, f.blank});
            checkOutput("frame_err", {24'd0, err}, {24'd0, f.err});
         end
      end
   end

   initial begin
      rst = 1'b1;
      an  = 8'hFF;
      seg = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] reset state");
      checkOutput("rst_digits", digits, 32'h0);
      checkOutput("rst_dp", {24'd0, dp}, 32'h0);
      checkOutput("rst_blank", {24'd0, blank}, 32'hFF);
      checkOutput("rst_err", {24'd0, err}, 32'h0);
      checkOutput("rst_fv", {31'd0, frame_valid}, 32'h0);

      $display("[TB] scan 01234567");
      pushFrame(32'h76543210, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 8; i++) showDigit(i, 4'(i), 1'b0, 4);
      checkOutput("t1_fv_at_latch", {31'd0, frame_valid}, 32'h0);
      checkOutput("t1_digits", digits, 32'h76543210);
      showDigit(7, 4'h7, 1'b0, 1);
      checkOutput("t1_fv_pulse", {31'd0, frame_valid}, 32'h1);
      showDigit(7, 4'h7, 1'b0, 1);
      checkOutput("t1_fv_one_cycle", {31'd0, frame_valid}, 32'h0);
      checkOutput("t1_frame_count", frameCount, 32'd1);

      $display("[TB] glitch, blank, error, invalid select");
      pushFrame(32'h700ED301, 8'h02, 8'h20, 8'h40);
      showDigit(2, 4'hA, 1'b0, 4);
      checkOutput("t2_prelatch_A", {28'd0, digits[11:8]}, 32'hA);
      showDigit(2, 4'h2, 1'b0, 3);
      checkOutput("t2_glitch_ignored", {28'd0, digits[11:8]}, 32'hA);
      showDigit(2, 4'h3, 1'b0, 4);
      checkOutput("t2_latched_3", {28'd0, digits[11:8]}, 32'h3);
      showDigit(0, 4'h1, 1'b0, 4);
      showDigit(1, 4'h0, 1'b1, 4);
      applyStimulus(8'hFC, segOf(4'h8, 1'b0), 10);
      checkOutput("t4_digits_unchanged", digits, 32'h76543301);
      checkOutput("t4_fv_low", {31'd0, frame_valid}, 32'h0);
      checkOutput("t4_no_frame", frameCount, 32'd1);
      showDigit(3, 4'hD, 1'b0, 4);
      showDigit(4, 4'hE, 1'b0, 4);
      applyStimulus(anOf(5), 8'hFF, 4);
      applyStimulus(anOf(6), 8'hFD, 4);
      checkOutput("t3_blank", {24'd0, blank}, 32'h20);
      checkOutput("t3_err", {24'd0, err}, 32'h40);
      checkOutput("t3_nibbles_zero", {24'd0, digits[27:20]}, 32'h0);
      showDigit(7, 4'h7, 1'b0, 4);
      showDigit(7, 4'h7, 1'b0, 2);
      checkOutput("t2_frame_count", frameCount, 32'd2);

      $display("[TB] reset mid-scan then FEDCBA98");
      for (int i = 0; i < 5; i++) showDigit(i, 4'h9, 1'b0, 4);
      #3;
      rst = 1'b1;
      an  = 8'hFF;
      seg = 8'hFF;
      #1;
      checkOutput("t5_rst_digits", digits, 32'h0);
      checkOutput("t5_rst_blank", {24'd0, blank}, 32'hFF);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      fcBase = frameCount;
      pushFrame(32'h89ABCDEF, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 7; i++) showDigit(i, 4'(15 - i), 1'b0, 4);
      checkOutput("t5_no_early_frame", frameCount, fcBase);
      showDigit(7, 4'h8, 1'b0, 4);
      showDigit(7, 4'h8, 1'b0, 2);
      checkOutput("t5_one_frame", frameCount, fcBase + 1);

      $display("[TB] long hold then continuous rescans");
      fcBase = frameCount;
      pushFrame(32'h76543218, 8'h01, 8'h00, 8'h00);
      showDigit(0, 4'h8, 1'b1, 20);
      checkOutput("t6_dp0", {31'd0, dp[0]}, 32'h1);
      checkOutput("t6_nib0", {28'd0, digits[3:0]}, 32'h8);
      for (int i = 1; i < 8; i++) showDigit(i, 4'(i), 1'b0, 4);
      pushFrame(32'h76543218, 8'h01, 8'h00, 8'h00);
      showDigit(0, 4'h8, 1'b1, 4);
      for (int i = 1; i < 8; i++) showDigit(i, 4'(i), 1'b0, 4);
      showDigit(7, 4'h7, 1'b0, 2);
      checkOutput("t6_two_frames", frameCount, fcBase + 2);
      checkOutput("queue_drained", expQ.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
